// File: rtl/hand_pkg.sv
// Shared definitions for the valid/ready handshake fork block.
package hand_pkg;

    localparam int FORK_CNT_W = 16;

    typedef enum logic [0:0] {
        HF_EMPTY = 1'b0,
        HF_FULL  = 1'b1
    } hf_state_e;

endpackage

// File: rtl/hand_fork.sv
// Registered eager fork: one upstream beat is broadcast to CHL consumers that accept independently.
// Optional completed-entry counter port fork_cnt is built when HAND_FORK_CNT_EN is defined.
module hand_fork
    import hand_pkg::*;
#(
    parameter int CHL = 2,
    parameter int DW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    output logic [CHL-1:0]        m_valid,
    input  logic [CHL-1:0]        m_ready,
`ifdef HAND_FORK_CNT_EN
    output logic [FORK_CNT_W-1:0] fork_cnt,
`endif
    output logic [DW-1:0]         m_data
);

    hf_state_e      state_r;
    hf_state_e      state_nx_s;
    logic [CHL-1:0] pend_r;
    logic [CHL-1:0] pend_nx_s;
    logic [DW-1:0]  data_r;
    logic [DW-1:0]  data_nx_s;
    logic [CHL-1:0] rem_s;
    logic           full_s;
    logic           retire_s;
    logic           load_s;
    logic           s_ready_s;

    // Handshake bookkeeping and next-state selection.
    always_comb begin
        state_nx_s = state_r;
        pend_nx_s  = pend_r;
        data_nx_s  = data_r;
        full_s     = (state_r == HF_FULL);
        rem_s      = pend_r & ~m_ready;
        retire_s   = full_s & (rem_s == {CHL{1'b0}});
        // s_ready depends on m_ready on purpose so a retiring entry can be replaced in the same cycle.
        s_ready_s  = ~rst & (~full_s | retire_s);
        load_s     = s_valid & s_ready_s;
        case (state_r)
            HF_EMPTY: begin
                if (load_s) begin
                    state_nx_s = HF_FULL;
                    pend_nx_s  = {CHL{1'b1}};
                    data_nx_s  = s_data;
                end else begin
                    state_nx_s = HF_EMPTY;
                end
            end
            HF_FULL: begin
                if (load_s) begin
                    state_nx_s = HF_FULL;
                    pend_nx_s  = {CHL{1'b1}};
                    data_nx_s  = s_data;
                end else if (retire_s) begin
                    state_nx_s = HF_EMPTY;
                    pend_nx_s  = {CHL{1'b0}};
                end else begin
                    pend_nx_s  = rem_s;
                end
            end
            default: begin
                state_nx_s = HF_EMPTY;
                pend_nx_s  = {CHL{1'b0}};
            end
        endcase
    end

    // Entry state register; reset drops any held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HF_EMPTY;
            pend_r  <= {CHL{1'b0}};
            data_r  <= {DW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            pend_r  <= pend_nx_s;
            data_r  <= data_nx_s;
        end
    end

`ifdef HAND_FORK_CNT_EN
    logic [FORK_CNT_W-1:0] cnt_r;

    // Completed-entry counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {FORK_CNT_W{1'b0}};
        end else if (retire_s) begin
            cnt_r <= cnt_r + {{(FORK_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign fork_cnt = cnt_r;
`endif

    assign s_ready = s_ready_s;
    assign m_valid = pend_r;
    assign m_data  = data_r;

endmodule

// File: tb/tb_hand_fork.sv
// Self-checking bench for hand_fork: directed scenarios, then random traffic against a per-channel delivery model.
module tb_hand_fork;

    localparam int CHL = 2;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic [CHL-1:0] m_valid;
    logic [CHL-1:0] m_ready;
    logic [DW-1:0]  m_data;
`ifdef HAND_FORK_CNT_EN
    logic [15:0]    fork_cnt;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: one entry owed to a set of channels, plus per-channel expected delivery queues.
    bit             ent;
    bit             owed [CHL];
    logic [DW-1:0]  ent_data;
    logic [15:0]    mdl_cnt;
    logic [DW-1:0]  chq [CHL][$];

    hand_fork #(.CHL(CHL), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
`ifdef HAND_FORK_CNT_EN
        .fork_cnt(fork_cnt),
`endif
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent      = 1'b0;
        ent_data = '0;
        mdl_cnt  = 16'd0;
        for (int i = 0; i < CHL; i++) begin
            owed[i] = 1'b0;
            chq[i].delete();
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model, cross the edge.
    task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic [CHL-1:0] mr, input logic rs);
        logic [CHL-1:0] exp_mv;
        bit             all_done;
        bit             exp_sr;
        bit             accept;
        rst = rs; s_valid = sv; s_data = sd; m_ready = mr;
        #2;
        all_done = 1'b1;
        for (int i = 0; i < CHL; i++) begin
            exp_mv[i] = owed[i];
            if (owed[i] && !mr[i]) all_done = 1'b0;
        end
        exp_sr = !rs && (!ent || all_done);
        chk("m_valid", {30'd0, m_valid}, {30'd0, exp_mv});
        chk("m_data",  {24'd0, m_data},  {24'd0, ent_data});
        chk("s_ready", {31'd0, s_ready}, {31'd0, exp_sr});
`ifdef HAND_FORK_CNT_EN
        chk("fork_cnt", {16'd0, fork_cnt}, {16'd0, mdl_cnt});
`endif
        // Every observed handshake must deliver the next beat owed to that channel, exactly once.
        for (int i = 0; i < CHL; i++) begin
            if (m_valid[i] === 1'b1 && mr[i]) begin
                if (chq[i].size() == 0) begin
                    chk("dup_beat", 32'd1, 32'd0);
                end else begin
                    chk("deliver", {24'd0, m_data}, {24'd0, chq[i].pop_front()});
                end
            end
        end
        accept = sv && exp_sr;
        if (rs) begin
            model_reset();
        end else begin
            if (ent && all_done) mdl_cnt = mdl_cnt + 16'd1;
            if (accept) begin
                ent      = 1'b1;
                ent_data = sd;
                for (int i = 0; i < CHL; i++) begin
                    owed[i] = 1'b1;
                    chq[i].push_back(sd);
                end
            end else if (ent && all_done) begin
                ent = 1'b0;
                for (int i = 0; i < CHL; i++) owed[i] = 1'b0;
            end else if (ent) begin
                for (int i = 0; i < CHL; i++) if (mr[i]) owed[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = '0;
        model_reset();
        @(posedge clk);
        #1;
        // Reset held, then idle.
        cycle(1'b0, 8'h00, 2'b00, 1'b1);
        cycle(1'b0, 8'h00, 2'b00, 1'b0);
        // Streaming with all consumers ready.
        cycle(1'b1, 8'h11, 2'b11, 1'b0);
        cycle(1'b1, 8'h22, 2'b11, 1'b0);
        cycle(1'b1, 8'h33, 2'b11, 1'b0);
        cycle(1'b0, 8'h00, 2'b11, 1'b0);
        cycle(1'b0, 8'h00, 2'b11, 1'b0);
        // Skewed acceptance: ch0 takes it early, ch1 holds off.
        cycle(1'b1, 8'hA5, 2'b00, 1'b0);
        cycle(1'b0, 8'h00, 2'b01, 1'b0);
        cycle(1'b0, 8'h00, 2'b01, 1'b0);
        cycle(1'b0, 8'h00, 2'b01, 1'b0);
        cycle(1'b0, 8'h00, 2'b10, 1'b0);
        cycle(1'b0, 8'h00, 2'b00, 1'b0);
        // Retire and load on the same edge.
        cycle(1'b1, 8'hA5, 2'b00, 1'b0);
        cycle(1'b0, 8'h00, 2'b01, 1'b0);
        cycle(1'b1, 8'h5A, 2'b10, 1'b0);
        cycle(1'b0, 8'h00, 2'b00, 1'b0);
        cycle(1'b0, 8'h00, 2'b11, 1'b0);
        // Reset while ch1 still owes a beat.
        cycle(1'b1, 8'h3C, 2'b00, 1'b0);
        cycle(1'b0, 8'h00, 2'b01, 1'b0);
        cycle(1'b0, 8'h00, 2'b00, 1'b1);
        cycle(1'b0, 8'h00, 2'b11, 1'b0);
        cycle(1'b0, 8'h00, 2'b11, 1'b0);
        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                  ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end
`ifdef HAND_FORK_CNT_EN
        // Counter wrap after 65536 retires.
        cycle(1'b0, 8'h00, 2'b00, 1'b1);
        for (int n = 0; n < 65536; n++) cycle(1'b1, 8'(n), 2'b11, 1'b0);
        cycle(1'b0, 8'h00, 2'b11, 1'b0);
        chk("cnt_wrap", {16'd0, fork_cnt}, 32'h0000_0000);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
